// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED PWM engine: prescaled period counter, per-channel off/pwm/blink/breathe
// modes, with configuration shadowed at period boundaries so register writes never glitch a LED.
module led_pwm_ctrl #(
  parameter int CH   = 6,
  parameter int W    = 8,
  parameter int PS_W = 16,
  parameter int BL_W = 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              enable,
  input  logic [PS_W-1:0]   prescale,
  input  logic [BL_W-1:0]   blink_len,
  input  logic [2*CH-1:0]   mode,
  input  logic [W*CH-1:0]   duty,
  output logic [CH-1:0]     led,
  output logic              period_strobe,
  output logic              blink_phase
);

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_PWM     = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;

  logic [PS_W-1:0] ps_cnt;
  logic [W-1:0]    pwm_cnt;
  logic [BL_W-1:0] bl_cnt;
  logic [W-1:0]    level;
  logic            level_down;
  logic [2*CH-1:0] shadow_mode;
  logic [W*CH-1:0] shadow_duty;
  logic [CH-1:0]   led_next;

  logic tick;
  logic wrap;

  // >= rather than == so that lowering prescale mid-count wraps at once instead of stalling
  assign tick = (ps_cnt >= prescale);
  assign wrap = tick && (&pwm_cnt);

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [1:0]     sm;
    logic [W-1:0]   sd;
    logic [2*W-1:0] prod;
    logic [W-1:0]   eff;

    assign sm   = shadow_mode[2*g +: 2];
    assign sd   = shadow_duty[W*g +: W];
    assign prod = {{W{1'b0}}, sd} * {{W{1'b0}}, level};

    always_comb begin
      eff = '0;
      case (sm)
        MODE_OFF:     eff = '0;
        MODE_PWM:     eff = sd;
        MODE_BLINK:   eff = blink_phase ? sd : '0;
        MODE_BREATHE: eff = prod[2*W-1:W];
        default:      eff = '0;
      endcase
    end

    assign led_next[g] = (pwm_cnt < eff);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ps_cnt        <= '0;
      pwm_cnt       <= '0;
      bl_cnt        <= '0;
      level         <= '0;
      level_down    <= 1'b0;
      blink_phase   <= 1'b0;
      shadow_mode   <= '0;
      shadow_duty   <= '0;
      led           <= '0;
      period_strobe <= 1'b0;
    end else if (!enable) begin
      // idle: everything parked at period start, shadows track the live config
      ps_cnt        <= '0;
      pwm_cnt       <= '0;
      bl_cnt        <= '0;
      level         <= '0;
      level_down    <= 1'b0;
      blink_phase   <= 1'b0;
      shadow_mode   <= mode;
      shadow_duty   <= duty;
      led           <= '0;
      period_strobe <= 1'b0;
    end else begin
      led           <= led_next;
      period_strobe <= wrap;
      ps_cnt        <= tick ? '0 : ps_cnt + 1'b1;
      if (tick) begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
      if (wrap) begin
        shadow_mode <= mode;
        shadow_duty <= duty;
        if (bl_cnt == blink_len) begin
          bl_cnt      <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          bl_cnt <= bl_cnt + 1'b1;
        end
        // triangle: each end value is held for one extra wrap while direction flips
        if (!level_down) begin
          if (&level) level_down <= 1'b1;
          else        level      <= level + 1'b1;
        end else begin
          if (level == '0) level_down <= 1'b0;
          else             level      <= level - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Bench for led_pwm_ctrl: tick/wrap-count model checked every cycle, plus directed
// period-level measurements against hand-computed counts.
module tb_led_pwm_ctrl;
  localparam int CH   = 6;
  localparam int W    = 8;
  localparam int PS_W = 16;
  localparam int BL_W = 8;
  localparam int PER  = 256;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic              enable;
  logic [PS_W-1:0]   prescale;
  logic [BL_W-1:0]   blink_len;
  logic [2*CH-1:0]   mode;
  logic [W*CH-1:0]   duty;
  logic [CH-1:0]     led;
  logic              period_strobe;
  logic              blink_phase;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  led_pwm_ctrl #(.CH(CH), .W(W), .PS_W(PS_W), .BL_W(BL_W)) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .prescale(prescale),
    .blink_len(blink_len), .mode(mode), .duty(duty), .led(led),
    .period_strobe(period_strobe), .blink_phase(blink_phase)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: elapsed ticks since enable; position, wrap count, level and phase derive from it.
  int          m_cyc, m_ticks;
  logic [1:0]  m_smode [CH];
  int          m_sduty [CH];
  logic [CH-1:0] exp_led;
  bit          exp_strobe, exp_phase;
  int          m_wraps, m_pos, m_lvl, m_eff;
  bit          m_ph, m_tick, m_wrap;

  function automatic int tri_level(input int n);
    int p;
    p = n % (2 * PER);
    return (p <= PER - 1) ? p : (2 * PER - 1) - p;
  endfunction

  function automatic bit phase_of(input int n, input int len);
    return ((n / (len + 1)) % 2) == 1;
  endfunction

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_cyc = 0; m_ticks = 0;
      for (int i = 0; i < CH; i++) begin m_smode[i] = 2'd0; m_sduty[i] = 0; end
      exp_led = '0; exp_strobe = 1'b0; exp_phase = 1'b0;
    end else if (!enable) begin
      m_cyc = 0; m_ticks = 0;
      for (int i = 0; i < CH; i++) begin
        m_smode[i] = mode[2*i +: 2];
        m_sduty[i] = int'(duty[W*i +: W]);
      end
      exp_led = '0; exp_strobe = 1'b0; exp_phase = 1'b0;
    end else begin
      m_wraps = m_ticks / PER;
      m_pos   = m_ticks % PER;
      m_lvl   = tri_level(m_wraps);
      m_ph    = phase_of(m_wraps, int'(blink_len));
      for (int i = 0; i < CH; i++) begin
        case (m_smode[i])
          2'd0: m_eff = 0;
          2'd1: m_eff = m_sduty[i];
          2'd2: m_eff = m_ph ? m_sduty[i] : 0;
          default: m_eff = (m_sduty[i] * m_lvl) / PER;
        endcase
        exp_led[i] = (m_pos < m_eff);
      end
      m_tick = (m_cyc >= int'(prescale));
      m_wrap = m_tick && (m_pos == PER - 1);
      if (m_tick) begin m_cyc = 0; m_ticks++; end
      else        m_cyc++;
      exp_strobe = m_wrap;
      exp_phase  = phase_of(m_ticks / PER, int'(blink_len));
      if (m_wrap) begin
        for (int i = 0; i < CH; i++) begin
          m_smode[i] = mode[2*i +: 2];
          m_sduty[i] = int'(duty[W*i +: W]);
        end
      end
    end
  end

  always @(negedge aclk) begin
    if (chk_en) begin
      check("model_led", int'(led), int'(exp_led));
      check("model_strobe", int'(period_strobe), int'(exp_strobe));
      check("model_phase", int'(blink_phase), int'(exp_phase));
    end
  end

  task automatic set_ch(input int ch, input logic [1:0] m, input logic [W-1:0] d);
    mode[2*ch +: 2] = m;
    duty[W*ch +: W] = d;
  endtask

  task automatic rand_ch(input int ch);
    set_ch(ch, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
  endtask

  // Leaves the bench on the negedge where enable has just been raised (period start).
  task automatic restart();
    enable = 1'b0;
    @(negedge aclk);
    enable = 1'b1;
  endtask

  // Called at a period start; samples led[0] across the 256 cycles that reflect pwm 0..255.
  task automatic measure(output int highs, output int first_strobe,
                         input int change_k, input logic [W-1:0] new_duty);
    highs = 0;
    first_strobe = -1;
    for (int k = 1; k <= PER; k++) begin
      @(negedge aclk);
      if (k == change_k) duty[W-1:0] = new_duty;
      highs += int'(led[0]);
      if (period_strobe && first_strobe < 0) first_strobe = k;
    end
  endtask

  task automatic wait_strobe(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge aclk);
      if (period_strobe) seen = 1'b1;
    end
    check(name, int'(seen), 1);
  endtask

  int h, fs;
  int blink_exp_h [6] = '{0, 0, 255, 255, 255, 0};
  int blink_exp_p [6] = '{0, 0, 1, 1, 1, 0};

  initial begin
    aresetn = 1'b0; enable = 1'b1; prescale = '0; blink_len = 8'd2;
    mode = '0; duty = '0;
    set_ch(0, 2'd1, 8'd255);
    for (int c = 1; c < CH; c++) rand_ch(c);
    repeat (3) @(negedge aclk);
    check("reset_led", int'(led), 0);
    check("reset_strobe", int'(period_strobe), 0);
    check("reset_phase", int'(blink_phase), 0);

    chk_en = 1'b1;
    enable = 1'b0;
    aresetn = 1'b1;
    h = 0;
    repeat (300) @(negedge aclk) h += int'(led != '0);
    check("idle_led_high", h, 0);

    set_ch(0, 2'd1, 8'd64);
    restart();
    measure(h, fs, 0, 8'd0);
    check("pwm64_highs_p0", h, 64);
    check("pwm64_strobe_p0", fs, 256);
    measure(h, fs, 0, 8'd0);
    check("pwm64_highs_p1", h, 64);
    check("pwm64_strobe_p1", fs, 256);

    set_ch(0, 2'd1, 8'd0);
    restart();
    measure(h, fs, 0, 8'd0);
    check("pwm0_highs", h, 0);

    set_ch(0, 2'd1, 8'd255);
    restart();
    measure(h, fs, 0, 8'd0);
    check("pwm255_highs", h, 255);

    set_ch(0, 2'd1, 8'd64);
    restart();
    measure(h, fs, 100, 8'd192);
    check("shadow_cur_period", h, 64);
    measure(h, fs, 0, 8'd0);
    check("shadow_next_period", h, 192);

    blink_len = 8'd2;
    set_ch(0, 2'd2, 8'd255);
    restart();
    wait_strobe(300, "blink_first_strobe");
    for (int p = 0; p < 6; p++) begin
      check($sformatf("blink_phase_%0d", p), int'(blink_phase), blink_exp_p[p]);
      measure(h, fs, 0, 8'd0);
      check($sformatf("blink_highs_%0d", p), h, blink_exp_h[p]);
    end

    set_ch(0, 2'd3, 8'd255);
    restart();
    wait_strobe(300, "breathe_wrap1");
    measure(h, fs, 0, 8'd0);
    check("breathe_lvl1", h, 0);
    measure(h, fs, 0, 8'd0);
    check("breathe_lvl2", h, 1);
    for (int n = 3; n < 255; n++) wait_strobe(300, "breathe_wrap");
    measure(h, fs, 0, 8'd0);
    check("breathe_lvl255", h, 254);
    measure(h, fs, 0, 8'd0);
    check("breathe_hold255", h, 254);
    measure(h, fs, 0, 8'd0);
    check("breathe_lvl254", h, 253);

    prescale = 16'd3;
    set_ch(0, 2'd1, 8'd1);
    restart();
    h = 0; fs = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge aclk);
      if (k == 2) prescale = 16'd0;
      if (k <= 10) h += int'(led[0]);
      if (period_strobe && fs < 0) fs = k;
    end
    check("presc_drop_highs", h, 3);
    check("presc_drop_strobe", fs, 258);

    set_ch(0, 2'd1, 8'd64);
    restart();
    repeat (100) @(negedge aclk);
    enable = 1'b0;
    @(negedge aclk);
    check("disable_led", int'(led), 0);
    check("disable_strobe", int'(period_strobe), 0);
    check("disable_phase", int'(blink_phase), 0);
    enable = 1'b1;
    measure(h, fs, 0, 8'd0);
    check("reenable_highs", h, 64);
    check("reenable_strobe", fs, 256);

    for (int seg = 0; seg < 6; seg++) begin
      enable = 1'b0;
      prescale  = 16'($urandom_range(0, 3));
      blink_len = 8'($urandom_range(0, 2));
      for (int c = 0; c < CH; c++) rand_ch(c);
      @(negedge aclk);
      enable = 1'b1;
      for (int c = 0; c < 2000; c++) begin
        @(negedge aclk);
        if ($urandom_range(0, 99) < 3) rand_ch(int'($urandom_range(0, CH - 1)));
        if ($urandom_range(0, 199) == 0) prescale = 16'($urandom_range(0, 3));
        if (seg == 2 && c == 1000) begin
          #2 aresetn = 1'b0;
          #1;
          check("async_rst_led", int'(led), 0);
          check("async_rst_strobe", int'(period_strobe), 0);
          check("async_rst_phase", int'(blink_phase), 0);
          @(negedge aclk);
          aresetn = 1'b1;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
